// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit.
// Holds state encodings, opcode constants, ALUop contract with alu_control,
// datapath select encodings and the packed control-word type.
package mc_pkg;

   localparam int unsigned OPW    = 6;
   localparam int unsigned ALUOPW = 3;

   typedef enum logic [3:0] {
      StFetch    = 4'd0,
      StDecode   = 4'd1,
      StMemAdr   = 4'd2,
      StMemRd    = 4'd3,
      StMemWb    = 4'd4,
      StMemWr    = 4'd5,
      StRtExec   = 4'd6,
      StRtWb     = 4'd7,
      StBeq      = 4'd8,
      StAddiExec = 4'd9,
      StAddiWb   = 4'd10,
      StJump     = 4'd11
   } state_t;

   localparam logic [OPW-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OPW-1:0] OP_LW    = 6'b100011;
   localparam logic [OPW-1:0] OP_SW    = 6'b101011;
   localparam logic [OPW-1:0] OP_BEQ   = 6'b000100;
   localparam logic [OPW-1:0] OP_ADDI  = 6'b001000;
   localparam logic [OPW-1:0] OP_J     = 6'b000010;

   localparam logic [ALUOPW-1:0] ALUOP_ADD   = 3'b000;
   localparam logic [ALUOPW-1:0] ALUOP_SUB   = 3'b001;
   localparam logic [ALUOPW-1:0] ALUOP_RTYPE = 3'b100;

   localparam logic [1:0] PC_SRC_ALU    = 2'b00;
   localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

   localparam logic [1:0] SRCB_B       = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   typedef struct packed {
      logic              mem_req;
      logic              mem_write;
      logic              iord;
      logic              ir_write;
      logic              pc_en;
      logic [1:0]        pc_src;
      logic              alu_src_a;
      logic [1:0]        alu_src_b;
      logic [ALUOPW-1:0] alu_op;
      logic              reg_dst;
      logic              mem_to_reg;
      logic              reg_write;
      logic              instr_done;
      logic              illegal_op;
   } ctrl_t;

   function automatic logic op_is_legal(input logic [OPW-1:0] op);
      logic legal;
      case (op)
         OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: legal = 1'b1;
         default:                                       legal = 1'b0;
      endcase
      return legal;
   endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control-unit <-> datapath/memory signal bundle.
// master: control unit (reads opcode, zero, mem_ready; drives all controls).
// slave:  datapath side (drives opcode, zero, mem_ready; reads controls).
interface multicycle_control_if;
   import mc_pkg::*;

   logic [OPW-1:0]    opcode;
   logic              zero;
   logic              mem_ready;
   logic              mem_req;
   logic              mem_write;
   logic              iord;
   logic              ir_write;
   logic              pc_en;
   logic [1:0]        pc_src;
   logic              alu_src_a;
   logic [1:0]        alu_src_b;
   logic [ALUOPW-1:0] alu_op;
   logic              reg_dst;
   logic              mem_to_reg;
   logic              reg_write;
   logic              instr_done;
   logic              illegal_op;

   modport master (
      input  opcode, zero, mem_ready,
      output mem_req, mem_write, iord, ir_write, pc_en, pc_src, alu_src_a, alu_src_b,
             alu_op, reg_dst, mem_to_reg, reg_write, instr_done, illegal_op
   );

   modport slave (
      output opcode, zero, mem_ready,
      input  mem_req, mem_write, iord, ir_write, pc_en, pc_src, alu_src_a, alu_src_b,
             alu_op, reg_dst, mem_to_reg, reg_write, instr_done, illegal_op
   );

endinterface

// File: rtl/mc_output_decode.sv
// Combinational control-word decode for the multi-cycle control FSM.
// Inputs:  state, rst_n (forces an all-zero word while low), opcode (illegal
//          detection in DECODE), mem_ready (FETCH/MEMWR completion), zero (beq).
// Output:  ctrl, the full datapath control word.
module mc_output_decode
   import mc_pkg::*;
(
   input  state_t         state,
   input  logic           rst_n,
   input  logic [OPW-1:0] opcode,
   input  logic           mem_ready,
   input  logic           zero,
   output ctrl_t          ctrl
);

   always_comb begin
      ctrl = '0;
      if (rst_n) begin
         case (state)
            StFetch: begin
               ctrl.mem_req   = 1'b1;
               ctrl.iord      = 1'b0;
               ctrl.alu_src_a = 1'b0;
               ctrl.alu_src_b = SRCB_FOUR;
               ctrl.alu_op    = ALUOP_ADD;
               ctrl.pc_src    = PC_SRC_ALU;
               // IR and PC latch only on the cycle memory returns the word
               ctrl.ir_write  = mem_ready;
               ctrl.pc_en     = mem_ready;
            end
            StDecode: begin
               // branch target precomputed into ALUOut
               ctrl.alu_src_a = 1'b0;
               ctrl.alu_src_b = SRCB_IMM_SH2;
               ctrl.alu_op    = ALUOP_ADD;
               if (!op_is_legal(opcode)) begin
                  ctrl.illegal_op = 1'b1;
                  ctrl.instr_done = 1'b1;
               end
            end
            StMemAdr: begin
               ctrl.alu_src_a = 1'b1;
               ctrl.alu_src_b = SRCB_IMM;
               ctrl.alu_op    = ALUOP_ADD;
            end
            StMemRd: begin
               ctrl.mem_req = 1'b1;
               ctrl.iord    = 1'b1;
            end
            StMemWb: begin
               ctrl.reg_write  = 1'b1;
               ctrl.mem_to_reg = 1'b1;
               ctrl.reg_dst    = 1'b0;
               ctrl.instr_done = 1'b1;
            end
            StMemWr: begin
               ctrl.mem_req    = 1'b1;
               ctrl.mem_write  = 1'b1;
               ctrl.iord       = 1'b1;
               ctrl.instr_done = mem_ready;
            end
            StRtExec: begin
               ctrl.alu_src_a = 1'b1;
               ctrl.alu_src_b = SRCB_B;
               ctrl.alu_op    = ALUOP_RTYPE;
            end
            StRtWb: begin
               ctrl.reg_write  = 1'b1;
               ctrl.reg_dst    = 1'b1;
               ctrl.mem_to_reg = 1'b0;
               ctrl.instr_done = 1'b1;
            end
            StBeq: begin
               ctrl.alu_src_a  = 1'b1;
               ctrl.alu_src_b  = SRCB_B;
               ctrl.alu_op     = ALUOP_SUB;
               ctrl.pc_src     = PC_SRC_ALUOUT;
               ctrl.pc_en      = zero;
               ctrl.instr_done = 1'b1;
            end
            StAddiExec: begin
               ctrl.alu_src_a = 1'b1;
               ctrl.alu_src_b = SRCB_IMM;
               ctrl.alu_op    = ALUOP_ADD;
            end
            StAddiWb: begin
               ctrl.reg_write  = 1'b1;
               ctrl.reg_dst    = 1'b0;
               ctrl.mem_to_reg = 1'b0;
               ctrl.instr_done = 1'b1;
            end
            StJump: begin
               ctrl.pc_src     = PC_SRC_JUMP;
               ctrl.pc_en      = 1'b1;
               ctrl.instr_done = 1'b1;
            end
            default: ;  // unused encodings: every enable stays low
         endcase
      end
   end

endmodule

// File: rtl/multicycle_control.sv
// Main sequencing FSM of the multi-cycle MIPS datapath.
// Ports: clk (rising edge), rst_n (synchronous, active-low),
//        bus (master side: opcode/zero/mem_ready in, all datapath controls out).
// Holds the state register and next-state logic; outputs come from mc_output_decode.
module multicycle_control
   import mc_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   multicycle_control_if.master bus
);

   state_t state_q, state_d;
   ctrl_t  ctrl;

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= StFetch;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = StFetch;
      case (state_q)
         StFetch:  state_d = bus.mem_ready ? StDecode : StFetch;
         StDecode: begin
            case (bus.opcode)
               OP_LW, OP_SW: state_d = StMemAdr;
               OP_RTYPE:     state_d = StRtExec;
               OP_BEQ:       state_d = StBeq;
               OP_ADDI:      state_d = StAddiExec;
               OP_J:         state_d = StJump;
               default:      state_d = StFetch;
            endcase
         end
         // opcode stays valid from the IR for the whole instruction
         StMemAdr:   state_d = (bus.opcode == OP_SW) ? StMemWr : StMemRd;
         StMemRd:    state_d = bus.mem_ready ? StMemWb : StMemRd;
         StMemWr:    state_d = bus.mem_ready ? StFetch : StMemWr;
         StRtExec:   state_d = StRtWb;
         StAddiExec: state_d = StAddiWb;
         default:    state_d = StFetch;
      endcase
   end

   mc_output_decode u_output_decode (
      .state     (state_q),
      .rst_n     (rst_n),
      .opcode    (bus.opcode),
      .mem_ready (bus.mem_ready),
      .zero      (bus.zero),
      .ctrl      (ctrl)
   );

   assign bus.mem_req    = ctrl.mem_req;
   assign bus.mem_write  = ctrl.mem_write;
   assign bus.iord       = ctrl.iord;
   assign bus.ir_write   = ctrl.ir_write;
   assign bus.pc_en      = ctrl.pc_en;
   assign bus.pc_src     = ctrl.pc_src;
   assign bus.alu_src_a  = ctrl.alu_src_a;
   assign bus.alu_src_b  = ctrl.alu_src_b;
   assign bus.alu_op     = ctrl.alu_op;
   assign bus.reg_dst    = ctrl.reg_dst;
   assign bus.mem_to_reg = ctrl.mem_to_reg;
   assign bus.reg_write  = ctrl.reg_write;
   assign bus.instr_done = ctrl.instr_done;
   assign bus.illegal_op = ctrl.illegal_op;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: each instruction is expanded into
// its expected per-cycle control words (including random memory stalls), the
// matching stimulus is replayed, and every cycle is compared.
module tb_multicycle_control;

   typedef struct packed {
      logic       mem_req;
      logic       mem_write;
      logic       iord;
      logic       ir_write;
      logic       pc_en;
      logic [1:0] pc_src;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [2:0] alu_op;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic       instr_done;
      logic       illegal_op;
   } vec_t;

   typedef struct {
      int         kind;
      bit         r;
      bit         z;
      logic [5:0] op;
      vec_t       exp;
   } ent_t;

   localparam int K_FETCH = 0, K_DEC = 1, K_DEC_ILL = 2, K_MEMADR = 3, K_MEMRD = 4;
   localparam int K_MEMWB = 5, K_MEMWR = 6, K_RTEX = 7, K_RTWB = 8, K_BEQ = 9;
   localparam int K_ADDIEX = 10, K_ADDIWB = 11, K_JUMP = 12;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;
   int   n_instr;
   int   n_done;
   ent_t q[$];
   vec_t obs;

   multicycle_control_if bus_if ();

   multicycle_control dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign obs = '{mem_req: bus_if.mem_req, mem_write: bus_if.mem_write, iord: bus_if.iord,
                  ir_write: bus_if.ir_write, pc_en: bus_if.pc_en, pc_src: bus_if.pc_src,
                  alu_src_a: bus_if.alu_src_a, alu_src_b: bus_if.alu_src_b,
                  alu_op: bus_if.alu_op, reg_dst: bus_if.reg_dst,
                  mem_to_reg: bus_if.mem_to_reg, reg_write: bus_if.reg_write,
                  instr_done: bus_if.instr_done, illegal_op: bus_if.illegal_op};

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic bit is_legal(input logic [5:0] op);
      return op == 6'b000000 || op == 6'b100011 || op == 6'b101011 ||
             op == 6'b000100 || op == 6'b001000 || op == 6'b000010;
   endfunction

   // Expected control word for one step of an instruction
   function automatic vec_t step_exp(input int kind, input bit r, input bit z);
      vec_t v;
      v = '0;
      case (kind)
         K_FETCH:   begin v.mem_req = 1; v.alu_src_b = 2'b01; v.ir_write = r; v.pc_en = r; end
         K_DEC:     v.alu_src_b = 2'b11;
         K_DEC_ILL: begin v.alu_src_b = 2'b11; v.instr_done = 1; v.illegal_op = 1; end
         K_MEMADR:  begin v.alu_src_a = 1; v.alu_src_b = 2'b10; end
         K_MEMRD:   begin v.mem_req = 1; v.iord = 1; end
         K_MEMWB:   begin v.reg_write = 1; v.mem_to_reg = 1; v.instr_done = 1; end
         K_MEMWR:   begin v.mem_req = 1; v.mem_write = 1; v.iord = 1; v.instr_done = r; end
         K_RTEX:    begin v.alu_src_a = 1; v.alu_op = 3'b100; end
         K_RTWB:    begin v.reg_write = 1; v.reg_dst = 1; v.instr_done = 1; end
         K_BEQ: begin
            v.alu_src_a = 1; v.alu_op = 3'b001; v.pc_src = 2'b01; v.pc_en = z;
            v.instr_done = 1;
         end
         K_ADDIEX:  begin v.alu_src_a = 1; v.alu_src_b = 2'b10; end
         K_ADDIWB:  begin v.reg_write = 1; v.instr_done = 1; end
         K_JUMP:    begin v.pc_src = 2'b10; v.pc_en = 1; v.instr_done = 1; end
         default: ;
      endcase
      return v;
   endfunction

   task automatic push(input int kind, input bit r, input bit z, input logic [5:0] op);
      ent_t e;
      e.kind = kind; e.r = r; e.z = z; e.op = op;
      e.exp  = step_exp(kind, r, z);
      q.push_back(e);
   endtask

   // A stalled step gets n cycles with ready low, then one with ready high
   task automatic push_wait(input int kind, input int n, input logic [5:0] op);
      for (int i = 0; i < n; i++) push(kind, 1'b0, 1'($urandom), op);
      push(kind, 1'b1, 1'($urandom), op);
   endtask

   task automatic gen_instr(input logic [5:0] op, input int fw, input int mw, input bit z);
      push_wait(K_FETCH, fw, 6'($urandom));
      case (op)
         6'b100011: begin
            push(K_DEC, 1'($urandom), 1'($urandom), op);
            push(K_MEMADR, 1'($urandom), 1'($urandom), op);
            push_wait(K_MEMRD, mw, op);
            push(K_MEMWB, 1'($urandom), 1'($urandom), op);
         end
         6'b101011: begin
            push(K_DEC, 1'($urandom), 1'($urandom), op);
            push(K_MEMADR, 1'($urandom), 1'($urandom), op);
            push_wait(K_MEMWR, mw, op);
         end
         6'b000000: begin
            push(K_DEC, 1'($urandom), 1'($urandom), op);
            push(K_RTEX, 1'($urandom), 1'($urandom), op);
            push(K_RTWB, 1'($urandom), 1'($urandom), op);
         end
         6'b001000: begin
            push(K_DEC, 1'($urandom), 1'($urandom), op);
            push(K_ADDIEX, 1'($urandom), 1'($urandom), op);
            push(K_ADDIWB, 1'($urandom), 1'($urandom), op);
         end
         6'b000100: begin
            push(K_DEC, 1'($urandom), 1'($urandom), op);
            push(K_BEQ, 1'($urandom), z, op);
         end
         6'b000010: begin
            push(K_DEC, 1'($urandom), 1'($urandom), op);
            push(K_JUMP, 1'($urandom), 1'($urandom), op);
         end
         default: push(K_DEC_ILL, 1'($urandom), 1'($urandom), op);
      endcase
      n_instr++;
   endtask

   task automatic run_queue();
      ent_t e;
      while (q.size() > 0) begin
         e = q.pop_front();
         @(negedge clk);
         bus_if.mem_ready = e.r;
         bus_if.zero      = e.z;
         bus_if.opcode    = e.op;
         #1;
         check_eq($sformatf("step_k%0d_op%b", e.kind, e.op), 32'(obs), 32'(e.exp));
         if (obs.instr_done) n_done++;
      end
   endtask

   task automatic reset_cycle();
      @(negedge clk);
      rst_n = 1'b0;
      bus_if.mem_ready = 1'b1;
      bus_if.zero      = 1'b1;
      #1;
      check_eq("reset_outputs", 32'(obs), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      logic [5:0] op;
      int         sel;
      n_tests = 0; n_fail = 0; n_instr = 0; n_done = 0;
      rst_n = 1'b0;
      bus_if.opcode = 6'b100011; bus_if.zero = 1'b0; bus_if.mem_ready = 1'b1;
      repeat (2) @(posedge clk);
      reset_cycle();

      // Directed: lw, sw with 3 stall cycles, R-type, beq taken/not, illegal
      gen_instr(6'b100011, 0, 0, 1'b0);
      gen_instr(6'b101011, 0, 3, 1'b0);
      gen_instr(6'b000000, 1, 0, 1'b0);
      gen_instr(6'b000100, 0, 0, 1'b1);
      gen_instr(6'b000100, 0, 0, 1'b0);
      gen_instr(6'b111111, 0, 0, 1'b0);
      gen_instr(6'b001000, 2, 0, 1'b0);
      gen_instr(6'b000010, 0, 0, 1'b0);
      run_queue();

      // Reset while stalled in MEMRD abandons the load
      push(K_FETCH, 1'b1, 1'b0, 6'b100011);
      push(K_DEC, 1'b0, 1'b0, 6'b100011);
      push(K_MEMADR, 1'b0, 1'b0, 6'b100011);
      push(K_MEMRD, 1'b0, 1'b0, 6'b100011);
      run_queue();
      reset_cycle();
      gen_instr(6'b100011, 1, 2, 1'b0);
      run_queue();

      // Randomized instruction stream
      for (int i = 0; i < 300; i++) begin
         sel = int'($urandom_range(0, 6));
         case (sel)
            0: op = 6'b100011;
            1: op = 6'b101011;
            2: op = 6'b000000;
            3: op = 6'b000100;
            4: op = 6'b001000;
            5: op = 6'b000010;
            default: begin
               op = 6'($urandom);
               if (is_legal(op)) op = 6'b111111;
            end
         endcase
         gen_instr(op, ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3)),
                   ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3)),
                   1'($urandom));
         run_queue();
      end

      check_eq("instr_done_count", 32'(n_done), 32'(n_instr));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
